// File: rtl/ram_sweep_pkg.sv
// Shared state type and word helpers for the sweep-cleared single-port RAM.
// Helpers work on a MAX_DW-wide word; callers zero-extend and truncate to their width.
package ram_sweep_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int MAX_DW = 512;
  localparam int MAX_BE = MAX_DW / 8;

  // Byte-lane merge: lanes with be set take new_w, the rest keep old_w.
  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // One extra bit on the compare so depth == 2**32 style limits cannot wrap.
  function automatic logic in_range(
    input logic [31:0] addr,
    input logic [32:0] depth
  );
    return ({1'b0, addr} < depth);
  endfunction

endpackage

// File: rtl/ram_sweep_counter.sv
// Clear-sweep sequencer: owns the CLEAR/IDLE state, the sweep address and the
// registered completion pulse. restart_i aborts any sweep and starts again at 0.
module ram_sweep_counter
  import ram_sweep_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart_i,
  output state_e                state_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o,
  output logic                  done_o
);

  // Equality against the last word avoids any overflow when DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  done_q;

  // Sweep state machine with registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else if (restart_i) begin
      state_q <= CLEAR;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= IDLE;
            addr_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            done_q  <= 1'b0;
          end
        end
        IDLE: begin
          done_q <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
          addr_q  <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state_o      = state_q;
  assign sweep_addr_o = addr_q;
  assign done_o       = done_q;

endmodule

// File: rtl/ram_sweep_ctrl.sv
// Single-port synchronous RAM with byte enables, address range checking,
// a one-cycle registered read path and a hardware clear sweep.
module ram_sweep_ctrl
  import ram_sweep_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_err,
  output logic                    busy,
  output logic                    clear_done
);

  state_e                  state_s;
  logic [ADDR_WIDTH-1:0]   sweep_addr_s;
  logic                    done_s;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    req_ready_s;
  logic                    addr_ok_s;
  logic                    wr_en_s;
  logic                    rd_en_s;
  logic [DATA_WIDTH-1:0]   mem_rd_s;
  logic [DATA_WIDTH-1:0]   merged_s;

  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   rd_data_d;
  logic                    rd_err_q;
  logic                    rd_err_d;

  ram_sweep_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_sweep (
    .clk          (clk),
    .reset        (reset),
    .restart_i    (clear_req),
    .state_o      (state_s),
    .sweep_addr_o (sweep_addr_s),
    .done_o       (done_s)
  );

  // Request decode; clear_req drops ready so it always wins over a same-cycle request.
  always_comb begin
    req_ready_s = 1'b0;
    addr_ok_s   = 1'b0;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    mem_rd_s    = '0;
    merged_s    = '0;
    rd_data_d   = '0;
    rd_err_d    = 1'b0;
    if (state_s == IDLE) begin
      req_ready_s = !clear_req;
    end else begin
      req_ready_s = 1'b0;
    end
    addr_ok_s = in_range(32'(req_addr), 33'(DEPTH));
    if (addr_ok_s) begin
      mem_rd_s = mem_q[req_addr];
    end else begin
      mem_rd_s = '0;
    end
    merged_s = DATA_WIDTH'(be_merge(MAX_DW'(mem_rd_s), MAX_DW'(req_wdata), MAX_BE'(req_be)));
    if (req_valid && req_ready_s) begin
      wr_en_s = req_write && addr_ok_s;
      rd_en_s = !req_write;
    end else begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end
    rd_data_d = mem_rd_s;
    rd_err_d  = !addr_ok_s;
  end

  // Storage array: the sweep owns the port while clearing, requests otherwise.
  always_ff @(posedge clk) begin
    if (state_s == CLEAR) begin
      mem_q[sweep_addr_s] <= INIT_VALUE;
    end else if (wr_en_s) begin
      mem_q[req_addr] <= merged_s;
    end
  end

  // Read response register; data and error hold until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_s;
      if (rd_en_s) begin
        rd_data_q <= rd_data_d;
        rd_err_q  <= rd_err_d;
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_err     = rd_err_q;
  assign busy       = (state_s == CLEAR);
  assign clear_done = done_s;

endmodule
